// File: rtl/fetch_if.sv
// Fetch-stage bus: PC/redirect inputs, instruction-memory handshake and IF/ID outputs.
interface fetch_if;
    logic [31:0] pc;
    logic        flush;
    logic        if_id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_incr;
    logic        stall_at_fetch;

    modport master (
        input  pc, flush, if_id_stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc_incr, stall_at_fetch
    );

    modport slave (
        output pc, flush, if_id_stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc_incr, stall_at_fetch
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, one-entry hold buffer for
// instructions returning under IF/ID stall, and squashing of fetches hit by a redirect.
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          rst,
    fetch_if.master       fetch_io
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] hold_q,  hold_d;
    logic        drop_q,  drop_d;

    logic        req_c;
    logic [31:0] addr_c;
    logic [31:0] instr_c;
    logic        valid_c;
    logic [31:0] pc_aligned;

    assign pc_aligned = {fetch_io.pc[31:2], 2'b00};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ISSUE;
            addr_q  <= 32'h0;
            hold_q  <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    // Next state and the combinational fetch outputs; an ack is either delivered,
    // parked in the hold buffer, or discarded when a redirect has overtaken it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        drop_d  = drop_q;
        req_c   = 1'b0;
        addr_c  = addr_q;
        instr_c = NOP_INSTR;
        valid_c = 1'b0;

        case (state_q)
            ISSUE: begin
                req_c  = 1'b1;
                addr_c = pc_aligned;
                if (fetch_io.imem_ack) begin
                    if (!fetch_io.flush) begin
                        if (!fetch_io.if_id_stall) begin
                            instr_c = fetch_io.imem_rdata;
                            valid_c = 1'b1;
                        end else begin
                            hold_d  = fetch_io.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end else begin
                    addr_d  = pc_aligned;
                    drop_d  = fetch_io.flush;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                req_c  = 1'b1;
                addr_c = addr_q;
                if (!fetch_io.imem_ack) begin
                    drop_d = drop_q | fetch_io.flush;
                end else begin
                    drop_d  = 1'b0;
                    state_d = ISSUE;
                    if (!(drop_q || fetch_io.flush)) begin
                        if (!fetch_io.if_id_stall) begin
                            instr_c = fetch_io.imem_rdata;
                            valid_c = 1'b1;
                        end else begin
                            hold_d  = fetch_io.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (fetch_io.flush) begin
                    state_d = ISSUE;
                end else if (!fetch_io.if_id_stall) begin
                    instr_c = hold_q;
                    valid_c = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Reset forces the port quiet immediately, independent of the clock.
    assign fetch_io.imem_req       = req_c & ~rst;
    assign fetch_io.imem_addr      = addr_c;
    assign fetch_io.instr_valid    = valid_c & ~rst;
    assign fetch_io.instr          = (valid_c && !rst) ? instr_c : NOP_INSTR;
    assign fetch_io.stall_at_fetch = rst | (~fetch_io.flush & ~valid_c);
    assign fetch_io.pc_incr        = fetch_io.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clock;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_if bus ();

    fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clock    (clock),
        .rst      (rst),
        .fetch_io (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in terms of transactions: an outstanding request (address,
    // killed-by-redirect flag) and a parked instruction awaiting IF/ID.
    logic        m_pend, m_dead, m_held;
    logic [31:0] m_paddr, m_hdata;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_pend <= 1'b0; m_dead <= 1'b0; m_held <= 1'b0;
            m_paddr <= 32'h0; m_hdata <= NOP;
        end else if (m_held) begin
            if (bus.flush || !bus.if_id_stall) m_held <= 1'b0;
        end else if (bus.imem_ack) begin
            m_pend <= 1'b0;
            m_dead <= 1'b0;
            if (!(bus.flush || (m_pend && m_dead)) && bus.if_id_stall) begin
                m_held  <= 1'b1;
                m_hdata <= bus.imem_rdata;
            end
        end else if (!m_pend) begin
            m_pend  <= 1'b1;
            m_paddr <= {bus.pc[31:2], 2'b00};
            m_dead  <= bus.flush;
        end else begin
            m_dead <= m_dead | bus.flush;
        end
    end

    always @(negedge clock) begin : compare
        logic        e_req, e_val, e_stall, dead;
        logic [31:0] e_addr, e_instr;
        e_addr = 32'h0;
        dead   = 1'b0;
        if (rst) begin
            e_req = 1'b0; e_val = 1'b0; e_instr = NOP;
        end else if (m_held) begin
            e_req   = 1'b0;
            e_val   = !bus.flush && !bus.if_id_stall;
            e_instr = e_val ? m_hdata : NOP;
        end else begin
            e_req   = 1'b1;
            e_addr  = m_pend ? m_paddr : {bus.pc[31:2], 2'b00};
            dead    = bus.flush || (m_pend && m_dead);
            e_val   = bus.imem_ack && !dead && !bus.if_id_stall;
            e_instr = e_val ? bus.imem_rdata : NOP;
        end
        e_stall = rst ? 1'b1 : (bus.flush ? 1'b0 : !e_val);
        chk("m_req",   32'(bus.imem_req),       32'(e_req));
        chk("m_valid", 32'(bus.instr_valid),    32'(e_val));
        chk("m_instr", bus.instr,               e_instr);
        chk("m_stall", 32'(bus.stall_at_fetch), 32'(e_stall));
        chk("m_incr",  bus.pc_incr,             bus.pc + 32'd4);
        if (e_req) chk("m_addr", bus.imem_addr, e_addr);
    end

    // One clock cycle of stimulus; returns just after the sampling edge.
    task automatic cyc(input logic [31:0] pc, input logic fl, input logic st,
                       input logic ack, input logic [31:0] rd);
        @(posedge clock);
        #1;
        rst = 1'b0;
        bus.pc = pc; bus.flush = fl; bus.if_id_stall = st;
        bus.imem_ack = ack; bus.imem_rdata = rd;
        @(negedge clock);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.pc = 32'h0; bus.flush = 1'b0; bus.if_id_stall = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        @(negedge clock);
        #1;
        chk("rst_req",   32'(bus.imem_req), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", bus.instr, NOP);
        chk("rst_stall", 32'(bus.stall_at_fetch), 32'h1);

        // zero-wait streaming
        for (int i = 0; i < 4; i++) begin
            cyc(32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b1, 32'hA000_0100 + 32'(i * 4));
            chk("zw_valid", 32'(bus.instr_valid), 32'h1);
            chk("zw_stall", 32'(bus.stall_at_fetch), 32'h0);
            chk("zw_instr", bus.instr, 32'hA000_0100 + 32'(i * 4));
            chk("zw_addr",  bus.imem_addr, 32'h100 + 32'(i * 4));
        end
        cyc(32'h100, 1'b0, 1'b0, 1'b1, 32'h1);
        chk("zw_incr", bus.pc_incr, 32'h104);

        // 3-cycle memory
        cyc(32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("w3_addr1", bus.imem_addr, 32'h200);
        chk("w3_stall1", 32'(bus.stall_at_fetch), 32'h1);
        cyc(32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("w3_addr2", bus.imem_addr, 32'h200);
        chk("w3_stall2", 32'(bus.stall_at_fetch), 32'h1);
        chk("w3_valid2", 32'(bus.instr_valid), 32'h0);
        cyc(32'h200, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        chk("w3_addr3", bus.imem_addr, 32'h200);
        chk("w3_valid3", 32'(bus.instr_valid), 32'h1);
        chk("w3_instr", bus.instr, 32'h1234_5678);

        // ack under stall, hold, release
        cyc(32'h204, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("hs_valid0", 32'(bus.instr_valid), 32'h0);
        chk("hs_stall0", 32'(bus.stall_at_fetch), 32'h1);
        cyc(32'h204, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("hs_req", 32'(bus.imem_req), 32'h0);
        chk("hs_stall1", 32'(bus.stall_at_fetch), 32'h1);
        cyc(32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("hs_rel_valid", 32'(bus.instr_valid), 32'h1);
        chk("hs_rel_instr", bus.instr, 32'hDEAD_BEEF);
        chk("hs_rel_req", 32'(bus.imem_req), 32'h0);
        cyc(32'h208, 1'b0, 1'b0, 1'b1, 32'h0000_0208);
        chk("hs_next_addr", bus.imem_addr, 32'h208);
        chk("hs_next_req", 32'(bus.imem_req), 32'h1);

        // flush during WAIT
        cyc(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("fw_addr_hold", bus.imem_addr, 32'h300);
        chk("fw_stall_fl", 32'(bus.stall_at_fetch), 32'h0);
        cyc(32'h400, 1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD);
        chk("fw_stale_valid", 32'(bus.instr_valid), 32'h0);
        chk("fw_stale_addr", bus.imem_addr, 32'h300);
        cyc(32'h400, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
        chk("fw_new_addr", bus.imem_addr, 32'h400);
        chk("fw_new_valid", 32'(bus.instr_valid), 32'h1);

        // flush during HOLD
        cyc(32'h500, 1'b0, 1'b1, 1'b1, 32'h5555_5555);
        cyc(32'h500, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("fh_valid", 32'(bus.instr_valid), 32'h0);
        chk("fh_stall", 32'(bus.stall_at_fetch), 32'h0);
        cyc(32'h600, 1'b0, 1'b0, 1'b1, 32'h0000_0600);
        chk("fh_new_addr", bus.imem_addr, 32'h600);
        chk("fh_new_instr", bus.instr, 32'h0000_0600);

        // flush coinciding with ack
        cyc(32'h700, 1'b1, 1'b0, 1'b1, 32'h7777_7777);
        chk("fa_valid", 32'(bus.instr_valid), 32'h0);
        chk("fa_stall", 32'(bus.stall_at_fetch), 32'h0);
        chk("fa_instr", bus.instr, NOP);
        cyc(32'h800, 1'b0, 1'b0, 1'b1, 32'h0000_0800);
        chk("fa_new_addr", bus.imem_addr, 32'h800);
        chk("fa_new_valid", 32'(bus.instr_valid), 32'h1);

        // flush in the issue cycle of a slow fetch
        cyc(32'h900, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(32'hA00, 1'b0, 1'b0, 1'b1, 32'h0999_0999);
        chk("fi_stale_valid", 32'(bus.instr_valid), 32'h0);
        cyc(32'hA00, 1'b0, 1'b0, 1'b1, 32'h0000_0A00);
        chk("fi_new_addr", bus.imem_addr, 32'hA00);

        // pc_incr wrap
        cyc(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
        chk("wrap_incr", bus.pc_incr, 32'h0000_0000);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);

        // async reset mid-WAIT
        cyc(32'hB00, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #3;
        chk("ar_pre_req", 32'(bus.imem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("ar_req", 32'(bus.imem_req), 32'h0);
        chk("ar_valid", 32'(bus.instr_valid), 32'h0);
        chk("ar_stall", 32'(bus.stall_at_fetch), 32'h1);
        @(negedge clock);
        cyc(32'hC00, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("ar_new_req", 32'(bus.imem_req), 32'h1);
        chk("ar_new_addr", bus.imem_addr, 32'hC00);
        cyc(32'hC00, 1'b0, 1'b0, 1'b1, 32'h0000_0C00);
        chk("ar_new_valid", 32'(bus.instr_valid), 32'h1);
        chk("ar_new_instr", bus.instr, 32'h0000_0C00);

        cyc(32'hC04, 1'b0, 1'b0, 1'b1, 32'h0000_0C04);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
